// File: rtl/control_unit.sv
// control_unit: multicycle MIPS-style Moore controller. Sequences each
// instruction through FETCH/DECODE and its execution states, drives the
// datapath control lines from the registered state and counts retired
// instructions.
module control_unit #(
    parameter int OPC_W = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic [OPC_W-1:0] funct,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             ALUSrcA,
    output logic             RegWrite,
    output logic             RegDst,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUOp,
    output logic [3:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'h00);
    localparam logic [OPC_W-1:0] OP_JUMP  = OPC_W'(6'h02);
    localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'h04);
    localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'h08);
    localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'h23);
    localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'h2B);
    localparam logic [OPC_W-1:0] OP_HALT  = OPC_W'(6'h3F);

    localparam logic [OPC_W-1:0] FN_ADD = OPC_W'(6'h20);
    localparam logic [OPC_W-1:0] FN_SUB = OPC_W'(6'h22);
    localparam logic [OPC_W-1:0] FN_AND = OPC_W'(6'h24);
    localparam logic [OPC_W-1:0] FN_OR  = OPC_W'(6'h25);
    localparam logic [OPC_W-1:0] FN_SLT = OPC_W'(6'h2A);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t           cur_state;
    state_t           next_state;
    logic [OPC_W-1:0] opcode_q;
    logic [OPC_W-1:0] funct_q;
    logic [3:0]       rtype_aluop;
    logic             rtype_ok;
    logic             retire;

    // State register; reset returns to FETCH without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (reset) cur_state <= S_FETCH;
        else       cur_state <= next_state;
    end

    // Capture the instruction fields while leaving DECODE; later states
    // see these copies even if the IR inputs move.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode_q <= '0;
            funct_q  <= '0;
        end else if (cur_state == S_DECODE) begin
            opcode_q <= opcode;
            funct_q  <= funct;
        end
    end

    // An instruction retires on the last state of its path (the one that
    // always returns to FETCH); NOP and HALT never get here.
    assign retire = (cur_state inside {S_MEMWB, S_MEMWR, S_RWB, S_BEQ, S_JUMP, S_ADDIWB});

    // Retired-instruction counter, wraps naturally at its width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       instr_count <= '0;
        else if (retire) instr_count <= instr_count + CNT_W'(1);
    end

    // Next-state selection; the opcode input is looked at only in DECODE.
    always_comb begin
        // NOTE: default assigned first so no path through the case leaves it unassigned (no latch).
        next_state = S_FETCH;
        case (cur_state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) next_state = S_MEMADR;
                else if (opcode == OP_RTYPE)            next_state = S_EXEC;
                else if (opcode == OP_BEQ)              next_state = S_BEQ;
                else if (opcode == OP_JUMP)             next_state = S_JUMP;
                else if (opcode == OP_ADDI)             next_state = S_ADDIEX;
                else if (opcode == OP_HALT)             next_state = S_HALT;
                else                                    next_state = S_FETCH;
            end
            S_MEMADR: next_state = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = S_MEMWB;
            S_EXEC:   next_state = S_RWB;
            S_ADDIEX: next_state = S_ADDIWB;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_FETCH;
        endcase
    end

    // Map the latched funct onto an ALU operation; unknown codes are flagged
    // so the write-back can be suppressed.
    always_comb begin
        rtype_aluop = ALU_AND;
        rtype_ok    = 1'b1;
        case (funct_q)
            FN_ADD:  rtype_aluop = ALU_ADD;
            FN_SUB:  rtype_aluop = ALU_SUB;
            FN_AND:  rtype_aluop = ALU_AND;
            FN_OR:   rtype_aluop = ALU_OR;
            FN_SLT:  rtype_aluop = ALU_SLT;
            default: rtype_ok    = 1'b0;
        endcase
    end

    // Moore output decode; everything is held at zero while reset is high.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = ALU_AND;
        if (!reset) begin
            case (cur_state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    ALUSrcB = 2'b01;
                    ALUOp   = ALU_ADD;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    ALUOp   = ALU_ADD;
                end
                S_MEMADR, S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp   = ALU_ADD;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = rtype_aluop;
                end
                S_RWB: begin
                    RegWrite = rtype_ok;
                    RegDst   = 1'b1;
                end
                S_BEQ: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                S_ADDIWB: RegWrite = 1'b1;
                default: ;
            endcase
        end
    end

    assign state  = cur_state;
    assign halted = (cur_state == S_HALT);

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter OPC_W, default 6, opcode/funct field width.
REQ-002 SHALL have parameter CNT_W, default 32, retired-instruction counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port opcode  input  OPC_W  IR[31:26], sampled in DECODE.
REQ-006 SHALL have port funct  input  OPC_W  IR[5:0], sampled in DECODE.
REQ-007 SHALL have ports PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst  output  1 each  datapath control lines.
REQ-008 SHALL have ports PCSource, ALUSrcB  output  2 each  datapath mux selects.
REQ-009 SHALL have port ALUOp  output  4  ALU operation code.
REQ-010 SHALL have port state  output  4  current FSM state, for debug.
REQ-011 SHALL have port halted  output  1  high while in HALT.
REQ-012 SHALL have port instr_count  output  CNT_W  count of retired instructions.

Function
REQ-013 SHALL be a Moore FSM: outputs decode from registered state only; inputs affect next state only.
REQ-014 SHALL encode states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BEQ=8, JUMP=9, ADDIEX=10, ADDIWB=11, HALT=12; codes 13-15 go to FETCH next cycle with all controls 0.
REQ-015 SHALL encode ALUOp AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111.
REQ-016 SHALL drive every control not listed for a state to 0.
REQ-017 FETCH: MemRead, IRWrite, PCWrite=1; IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00; next DECODE.
REQ-018 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD (branch target); next by opcode: 0x23/0x2B->MEMADR, 0x00->EXEC, 0x04->BEQ, 0x02->JUMP, 0x08->ADDIEX, 0x3F->HALT, other->FETCH (NOP, not counted).
REQ-019 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD; next MEMRD if latched opcode 0x23, else MEMWR.
REQ-020 MEMRD: MemRead=1, IorD=1; next MEMWB.
REQ-021 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; next FETCH.
REQ-022 MEMWR: MemWrite=1, IorD=1; next FETCH.
REQ-023 EXEC: ALUSrcA=1, ALUSrcB=00; ALUOp from latched funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT; next RWB.
REQ-024 RWB: RegWrite=1, RegDst=1, MemtoReg=0; suppress RegWrite if latched funct unsupported; next FETCH.
REQ-025 BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCWriteCond=1, PCSource=01; next FETCH.
REQ-026 JUMP: PCWrite=1, PCSource=10; next FETCH.
REQ-027 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD; next ADDIWB. ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; next FETCH.
REQ-028 HALT: all controls 0, halted=1; remain until reset.
REQ-029 SHALL latch opcode and funct into internal registers on the DECODE->next transition; later states use latched copies only.
REQ-030 instr_count SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR, RWB, BEQ, JUMP, ADDIWB; wraps modulo 2^CNT_W; never increments in HALT or NOP.
REQ-031 Cycle counts: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, NOP 2.

Reset
REQ-032 Asserting reset SHALL immediately set state=FETCH, instr_count=0, latched opcode/funct=0, halted=0.
REQ-033 While reset is high all control outputs SHALL be 0 (gated); FETCH controls appear on the first cycle after deassertion.
REQ-034 Reset mid-instruction SHALL abandon it without incrementing instr_count.

Verification
REQ-035 Reset, release, opcode=0x23 -> states 0,1,2,3,4,0; MemRead=1 in FETCH and MEMRD; RegWrite=1,MemtoReg=1 only in MEMWB; instr_count=1.
REQ-036 opcode=0x00, funct=0x22 -> EXEC ALUOp=0110, RWB RegWrite=1,RegDst=1; funct=0x3C -> RWB RegWrite=0; instr_count +1 each.
REQ-037 opcode=0x04 then 0x02 -> BEQ PCWriteCond=1,PCSource=01,ALUOp=0110; JUMP PCWrite=1,PCSource=10; 3 cycles each.
REQ-038 opcode changed to 0x2B during MEMADR after 0x23 decoded -> path still MEMRD (latched), not MEMWR.
REQ-039 opcode=0x3F -> HALT, halted=1, all controls 0 for 20 cycles, instr_count frozen; reset -> state 0, halted=0.
REQ-040 reset asserted asynchronously mid-EXEC -> state=0, controls 0 before next clock edge, instr_count=0.
